id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage LEGv8 CPU; captures decoded operands and control from Decode and presents them to Execute and the forwarding unit.
- Contains load-use hazard detection: stalls IF/ID and inserts a bubble when a load in EX feeds the instruction in ID.
- Handles branch flush, external hold and a saturating stall counter for performance monitoring.

Parameters:
- DATA_W, 64, operand/immediate width
- ALUOP_W, 3, ALU operation code width
- CNT_W, 16, stall counter width

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- id_rn  input  5  source register A address from Decode
- id_rm  input  5  source register B address from Decode (Rd for STUR/CBZ)
- id_uses_rn  input  1  instruction reads Rn
- id_uses_rm  input  1  instruction reads Rm
- id_rd  input  5  destination register
- id_reg_write  input  1  instruction writes register file
- id_mem_read  input  1  instruction is LDUR
- id_mem_write  input  1  instruction is STUR
- id_set_flags  input  1  instruction updates NZCV
- id_alu_op  input  ALUOP_W  ALU operation
- id_alu_src  input  1  1 = use immediate for ALU B
- id_da  input  DATA_W  register file read data A
- id_db  input  DATA_W  register file read data B
- id_imm  input  DATA_W  sign-extended immediate
- flush  input  1  branch taken in EX; squash ID instruction
- hold  input  1  global freeze (memory wait); register keeps contents
- ex_rn, ex_rm, ex_rd  output  5  registered addresses (ex_rn/ex_rm drive forwarding unit source_reg_1/2)
- ex_reg_write, ex_mem_read, ex_mem_write, ex_set_flags, ex_alu_src  output  1  registered control
- ex_alu_op  output  ALUOP_W  registered ALU op
- ex_da, ex_db, ex_imm  output  DATA_W  registered data
- stall  output  1  load-use stall to PC and IF/ID (hold their values)
- stall_count  output  CNT_W  number of bubbles inserted by load-use

Behaviour:
- Reset: all ex_* control 0, ex_alu_op 0, data outputs 0, ex_rn = ex_rm = ex_rd = 31, stall_count 0. Because ex_mem_read is 0, stall is 0.
- Bubble: all control bits 0, ex_rd = ex_rn = ex_rm = 31, ex_alu_op 0. Data fields are don't-care; the block drives 0.
- stall is combinational from registered EX state and ID inputs. stall = ex_mem_read & ex_rd != 31 & ((id_uses_rn & id_rn == ex_rd) | (id_uses_rm & id_rm == ex_rd)).
- Update priority at each rising edge:
  - reset: reset values.
  - flush: load bubble (flush wins over hold and stall).
  - hold: keep all contents; stall_count unchanged.
  - stall: load bubble; stall_count increments, saturating at all-ones.
  - otherwise: load all id_* fields.
- Latency: one cycle from id_* to ex_*. The load-use penalty is exactly one bubble. After the bubble, ex_mem_read = 0, so stall drops and the held ID instruction is captured on the next edge.
- The load in EX still proceeds during stall; only ID/IF are frozen.
- X31 as ex_rd never triggers stall; the zero register is never a dependency.
- Mid-operation reset overrides everything, including a pending stall or flush.
- stall is also computed while hold = 1 but has no effect on the register during hold.

Test Plan:
- Reset:
  - Stimulus: assert reset 2 cycles with random id_* inputs.
  - Response: ex_rd = 31, all control 0, stall 0, stall_count 0.
- Pass-through:
  - Stimulus: ADD X3,X1,X2 (id_rn=1, id_rm=2, id_rd=3, id_reg_write=1, id_da=5, id_db=7).
  - Response: next cycle ex_rn=1, ex_rm=2, ex_rd=3, ex_reg_write=1, ex_da=5, ex_db=7; stall 0.
- Load-use:
  - Stimulus: LDUR X4 latched (ex_mem_read=1, ex_rd=4), then ID holds ADD X5,X4,X6 with id_uses_rn=1.
  - Response: stall=1 that cycle. Next cycle is a bubble (ex_reg_write=0, ex_rd=31) with stall_count=1 and stall=0. Following cycle ex_rn=4, ex_rd=5.
- X31/no-use:
  - Stimulus (a): LDUR with ex_rd=31 and id_rn=31.
  - Stimulus (b): ex_rd=4 with id_rm=4, id_uses_rm=0.
  - Response: stall=0 in both cases.
- Flush vs stall:
  - Stimulus: flush=1 during the load-use condition.
  - Response: bubble loaded, stall_count unchanged.
  - Stimulus: flush=1 with hold=1.
  - Response: bubble loaded.
- Hold and saturation:
  - Stimulus: hold=1 for 3 cycles with changing id_*.
  - Response: ex_* stable.
  - Stimulus: force 2^CNT_W + 2 load-use stalls.
  - Response: stall_count = all-ones (0xFFFF).

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage LEGv8 core.
// Captures decoded operands/control from Decode, detects load-use hazards,
// inserts bubbles on stall or branch flush, freezes on hold, and counts
// load-use bubbles in a saturating counter.
module id_ex_stage #(
    parameter int DATA_W  = 64,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [4:0]         id_rn,
    input  logic [4:0]         id_rm,
    input  logic               id_uses_rn,
    input  logic               id_uses_rm,
    input  logic [4:0]         id_rd,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               id_set_flags,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic               id_alu_src,
    input  logic [DATA_W-1:0]  id_da,
    input  logic [DATA_W-1:0]  id_db,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic               flush,
    input  logic               hold,
    output logic [4:0]         ex_rn,
    output logic [4:0]         ex_rm,
    output logic [4:0]         ex_rd,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_set_flags,
    output logic               ex_alu_src,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic [DATA_W-1:0]  ex_da,
    output logic [DATA_W-1:0]  ex_db,
    output logic [DATA_W-1:0]  ex_imm,
    output logic               stall,
    output logic [CNT_W-1:0]   stall_count
);

    // X31 is the zero register: it never forms a data dependency.
    localparam logic [4:0] ZERO_REG = 5'd31;

    logic rn_hit;
    logic rm_hit;

    // Load-use hazard: load in EX whose destination is read by the ID instruction.
    always_comb begin
        rn_hit = id_uses_rn && (id_rn == ex_rd);
        rm_hit = id_uses_rm && (id_rm == ex_rd);
        stall  = ex_mem_read && (ex_rd != ZERO_REG) && (rn_hit || rm_hit);
    end

    // Pipeline register update: reset > flush > hold > stall > load.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_rn        <= ZERO_REG;
            ex_rm        <= ZERO_REG;
            ex_rd        <= ZERO_REG;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_set_flags <= 1'b0;
            ex_alu_src   <= 1'b0;
            ex_alu_op    <= '0;
            ex_da        <= '0;
            ex_db        <= '0;
            ex_imm       <= '0;
            stall_count  <= '0;
        end else if (flush || (!hold && stall)) begin
            // Flush and load-use stall both load a bubble; only the stall is counted.
            ex_rn        <= ZERO_REG;
            ex_rm        <= ZERO_REG;
            ex_rd        <= ZERO_REG;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_set_flags <= 1'b0;
            ex_alu_src   <= 1'b0;
            ex_alu_op    <= '0;
            ex_da        <= '0;
            ex_db        <= '0;
            ex_imm       <= '0;
            if (!flush && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
        end else if (!hold) begin
            ex_rn        <= id_rn;
            ex_rm        <= id_rm;
            ex_rd        <= id_rd;
            ex_reg_write <= id_reg_write;
            ex_mem_read  <= id_mem_read;
            ex_mem_write <= id_mem_write;
            ex_set_flags <= id_set_flags;
            ex_alu_src   <= id_alu_src;
            ex_alu_op    <= id_alu_op;
            ex_da        <= id_da;
            ex_db        <= id_db;
            ex_imm       <= id_imm;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a driver applies directed and random
// Decode traffic and queues the expected EX-side view; a monitor pops and
// compares on the falling edge. A second instance with a 4-bit counter
// exercises counter saturation within a short run.
module tb_id_ex_stage;

    localparam int DW = 64;

    typedef struct packed {
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic        uses_rn;
        logic        uses_rm;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        set_flags;
        logic [2:0]  alu_op;
        logic        alu_src;
        logic [63:0] da;
        logic [63:0] db;
        logic [63:0] imm;
    } id_t;

    typedef struct packed {
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        set_flags;
        logic [2:0]  alu_op;
        logic        alu_src;
        logic [63:0] da;
        logic [63:0] db;
        logic [63:0] imm;
    } ex_t;

    typedef struct {
        ex_t         ex;
        logic        stall;
        int unsigned cnt;
        int unsigned cnt_small;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        hold = 1'b0;
    logic [4:0]  id_rn, id_rm, id_rd;
    logic        id_uses_rn, id_uses_rm;
    logic        id_reg_write, id_mem_read, id_mem_write, id_set_flags, id_alu_src;
    logic [2:0]  id_alu_op;
    logic [63:0] id_da, id_db, id_imm;

    logic [4:0]  ex_rn, ex_rm, ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_set_flags, ex_alu_src;
    logic [2:0]  ex_alu_op;
    logic [63:0] ex_da, ex_db, ex_imm;
    logic        stall;
    logic [15:0] stall_count;

    logic [4:0]  s_rn, s_rm, s_rd;
    logic        s_reg_write, s_mem_read, s_mem_write, s_set_flags, s_alu_src;
    logic [2:0]  s_alu_op;
    logic [63:0] s_da, s_db, s_imm;
    logic        s_stall;
    logic [3:0]  s_stall_count;

    int unsigned checks = 0;
    int unsigned failures = 0;

    exp_t        sb[$];
    ex_t         m_ex;
    int unsigned m_cnt = 0;
    int unsigned m_cnt_s = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(64), .ALUOP_W(3), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_set_flags(id_set_flags), .id_alu_op(id_alu_op),
        .id_alu_src(id_alu_src), .id_da(id_da), .id_db(id_db), .id_imm(id_imm),
        .flush(flush), .hold(hold),
        .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_set_flags(ex_set_flags),
        .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .ex_da(ex_da), .ex_db(ex_db),
        .ex_imm(ex_imm), .stall(stall), .stall_count(stall_count)
    );

    id_ex_stage #(.DATA_W(64), .ALUOP_W(3), .CNT_W(4)) dut_small (
        .clk(clk), .reset(reset),
        .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_set_flags(id_set_flags), .id_alu_op(id_alu_op),
        .id_alu_src(id_alu_src), .id_da(id_da), .id_db(id_db), .id_imm(id_imm),
        .flush(flush), .hold(hold),
        .ex_rn(s_rn), .ex_rm(s_rm), .ex_rd(s_rd), .ex_reg_write(s_reg_write),
        .ex_mem_read(s_mem_read), .ex_mem_write(s_mem_write), .ex_set_flags(s_set_flags),
        .ex_alu_src(s_alu_src), .ex_alu_op(s_alu_op), .ex_da(s_da), .ex_db(s_db),
        .ex_imm(s_imm), .stall(s_stall), .stall_count(s_stall_count)
    );

    // ---------------- reference model ----------------
    function automatic ex_t bubble_val();
        ex_t b;
        b    = '0;
        b.rn = 5'd31;
        b.rm = 5'd31;
        b.rd = 5'd31;
        return b;
    endfunction

    function automatic logic model_stall(input ex_t e, input id_t d);
        logic dep;
        dep = (d.uses_rn && d.rn == e.rd) || (d.uses_rm && d.rm == e.rd);
        return e.mem_read && (e.rd != 5'd31) && dep;
    endfunction

    function automatic ex_t latch(input id_t d);
        ex_t e;
        e.rn = d.rn; e.rm = d.rm; e.rd = d.rd;
        e.reg_write = d.reg_write; e.mem_read = d.mem_read;
        e.mem_write = d.mem_write; e.set_flags = d.set_flags;
        e.alu_op = d.alu_op; e.alu_src = d.alu_src;
        e.da = d.da; e.db = d.db; e.imm = d.imm;
        return e;
    endfunction

    function automatic id_t rand_id();
        id_t d;
        int unsigned k;
        d = '0;
        k = $urandom_range(0, 5); d.rn = (k == 5) ? 5'd31 : 5'(k);
        k = $urandom_range(0, 5); d.rm = (k == 5) ? 5'd31 : 5'(k);
        k = $urandom_range(0, 5); d.rd = (k == 5) ? 5'd31 : 5'(k);
        if ($urandom_range(0, 7) == 0) d.rd = 5'($urandom);
        d.uses_rn   = 1'($urandom);
        d.uses_rm   = 1'($urandom);
        d.reg_write = 1'($urandom);
        d.mem_read  = ($urandom_range(0, 2) == 0);
        d.mem_write = 1'($urandom);
        d.set_flags = 1'($urandom);
        d.alu_op    = 3'($urandom);
        d.alu_src   = 1'($urandom);
        d.da        = {$urandom, $urandom};
        d.db        = {$urandom, $urandom};
        d.imm       = {$urandom, $urandom};
        return d;
    endfunction

    function automatic id_t mk(input logic [4:0] rn, input logic urn, input logic [4:0] rm,
                               input logic urm, input logic [4:0] rd, input logic rw,
                               input logic mr, input logic [63:0] da, input logic [63:0] db);
        id_t d;
        d = rand_id();
        d.rn = rn; d.uses_rn = urn; d.rm = rm; d.uses_rm = urm; d.rd = rd;
        d.reg_write = rw; d.mem_read = mr; d.da = da; d.db = db;
        return d;
    endfunction

    // One clock: sample point just after the edge, apply inputs, queue the
    // expected view for this cycle, then advance the model across the next edge.
    task automatic cycle(input logic r, input logic f, input logic h, input id_t d);
        exp_t e;
        logic st;
        @(posedge clk);
        #1;
        reset = r; flush = f; hold = h;
        id_rn = d.rn; id_rm = d.rm; id_uses_rn = d.uses_rn; id_uses_rm = d.uses_rm;
        id_rd = d.rd; id_reg_write = d.reg_write; id_mem_read = d.mem_read;
        id_mem_write = d.mem_write; id_set_flags = d.set_flags; id_alu_op = d.alu_op;
        id_alu_src = d.alu_src; id_da = d.da; id_db = d.db; id_imm = d.imm;
        st = model_stall(m_ex, d);
        e.ex = m_ex; e.stall = st; e.cnt = m_cnt; e.cnt_small = m_cnt_s;
        sb.push_back(e);
        if (r) begin
            m_ex = bubble_val(); m_cnt = 0; m_cnt_s = 0;
        end else if (f) begin
            m_ex = bubble_val();
        end else if (h) begin
            m_ex = m_ex;
        end else if (st) begin
            m_ex = bubble_val();
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt_s < 15) m_cnt_s++;
        end else begin
            m_ex = latch(d);
        end
    endtask

    // ---------------- monitor ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ex_rn", 64'(ex_rn), 64'(e.ex.rn));
                chk("ex_rm", 64'(ex_rm), 64'(e.ex.rm));
                chk("ex_rd", 64'(ex_rd), 64'(e.ex.rd));
                chk("ex_reg_write", 64'(ex_reg_write), 64'(e.ex.reg_write));
                chk("ex_mem_read", 64'(ex_mem_read), 64'(e.ex.mem_read));
                chk("ex_mem_write", 64'(ex_mem_write), 64'(e.ex.mem_write));
                chk("ex_set_flags", 64'(ex_set_flags), 64'(e.ex.set_flags));
                chk("ex_alu_src", 64'(ex_alu_src), 64'(e.ex.alu_src));
                chk("ex_alu_op", 64'(ex_alu_op), 64'(e.ex.alu_op));
                chk("ex_da", ex_da, e.ex.da);
                chk("ex_db", ex_db, e.ex.db);
                chk("ex_imm", ex_imm, e.ex.imm);
                chk("stall", 64'(stall), 64'(e.stall));
                chk("stall_count", 64'(stall_count), 64'(e.cnt));
                chk("small_stall_count", 64'(s_stall_count), 64'(e.cnt_small));
                chk("small_stall", 64'(s_stall), 64'(e.stall));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        id_t d;
        id_t ldr, add;
        int unsigned r;
        m_ex = bubble_val();
        d = rand_id();
        id_rn = d.rn; id_rm = d.rm; id_uses_rn = d.uses_rn; id_uses_rm = d.uses_rm;
        id_rd = d.rd; id_reg_write = d.reg_write; id_mem_read = d.mem_read;
        id_mem_write = d.mem_write; id_set_flags = d.set_flags; id_alu_op = d.alu_op;
        id_alu_src = d.alu_src; id_da = d.da; id_db = d.db; id_imm = d.imm;

        // Reset held two cycles with random Decode inputs.
        cycle(1'b1, 1'b0, 1'b0, rand_id());
        cycle(1'b1, 1'b0, 1'b0, rand_id());

        // ADD X3,X1,X2 pass-through.
        cycle(1'b0, 1'b0, 1'b0, mk(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 64'd5, 64'd7));
        cycle(1'b0, 1'b0, 1'b0, mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd31, 1'b0, 1'b0, 64'd0, 64'd0));

        // Load-use: LDUR X4, then ADD X5,X4,X6 held in ID for the bubble.
        ldr = mk(5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 64'd0, 64'd0);
        add = mk(5'd4, 1'b1, 5'd6, 1'b1, 5'd5, 1'b1, 1'b0, 64'd11, 64'd13);
        cycle(1'b0, 1'b0, 1'b0, ldr);
        cycle(1'b0, 1'b0, 1'b0, add);
        cycle(1'b0, 1'b0, 1'b0, add);
        cycle(1'b0, 1'b0, 1'b0, mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd31, 1'b0, 1'b0, 64'd0, 64'd0));

        // X31 destination and unused Rm never stall.
        cycle(1'b0, 1'b0, 1'b0, mk(5'd1, 1'b1, 5'd0, 1'b0, 5'd31, 1'b1, 1'b1, 64'd0, 64'd0));
        cycle(1'b0, 1'b0, 1'b0, mk(5'd31, 1'b1, 5'd31, 1'b1, 5'd7, 1'b1, 1'b0, 64'd1, 64'd2));
        cycle(1'b0, 1'b0, 1'b0, ldr);
        cycle(1'b0, 1'b0, 1'b0, mk(5'd0, 1'b0, 5'd4, 1'b0, 5'd7, 1'b1, 1'b0, 64'd1, 64'd2));

        // Flush during load-use, then flush together with hold.
        cycle(1'b0, 1'b0, 1'b0, ldr);
        cycle(1'b0, 1'b1, 1'b0, add);
        cycle(1'b0, 1'b0, 1'b0, add);
        cycle(1'b0, 1'b1, 1'b1, rand_id());
        cycle(1'b0, 1'b0, 1'b0, add);

        // Hold for three cycles with changing Decode inputs.
        cycle(1'b0, 1'b0, 1'b1, rand_id());
        cycle(1'b0, 1'b0, 1'b1, rand_id());
        cycle(1'b0, 1'b0, 1'b1, rand_id());
        cycle(1'b0, 1'b0, 0, mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 64'd3, 64'd4));

        // Reset while a load-use stall is pending.
        cycle(1'b0, 1'b0, 1'b0, ldr);
        cycle(1'b1, 1'b0, 1'b0, add);
        cycle(1'b0, 1'b0, 1'b0, add);

        // Back-to-back dependent loads (LDUR X4,[X4]) drive the small counter past saturation.
        ldr = mk(5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 64'd0, 64'd0);
        for (int i = 0; i < 44; i++) cycle(1'b0, 1'b0, 1'b0, ldr);

        // Random traffic with occasional flush, hold and reset.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 199);
            cycle((r == 0), (r >= 1 && r <= 12), (r >= 13 && r <= 37), rand_id());
        end

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
